spi_req_scheduler: RTL and testbench

Shares the single spi_controller between NUM_REQ hardware requesters, using round-robin arbitration. For each granted request it sequences the controller's register interface: a control-register write, then a data-register write that launches the transfer. It then polls the status register until the transfer completes and returns the controller's data register to the owner. It sits beside axi_interface in front of spi_controller and drives the same o_data_to_registers / o_wr_controll_reg / o_wr_data_reg strobes.

---
 rtl/spi_sched_pkg.sv | 28 ++
 rtl/spi_rr_arbiter.sv | 36 +++
 rtl/spi_req_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_spi_req_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sched_pkg.sv
// Shared definitions for the SPI request scheduler.
// Holds the FSM state encodings, the spi_controller register offsets, the
// default position of the busy flag in the status register and a small
// index-to-one-hot helper used by the top level.
package spi_sched_pkg;

    // Scheduler FSM state encodings
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WR_CTRL    = 3'd1;
    localparam logic [2:0] ST_WR_DATA    = 3'd2;
    localparam logic [2:0] ST_WAIT_START = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd4;
    localparam logic [2:0] ST_RESP       = 3'd5;

    // spi_controller register map (byte offsets)
    localparam logic [7:0] REG_CTRL_OFS   = 8'h00;
    localparam logic [7:0] REG_STATUS_OFS = 8'h04;
    localparam logic [7:0] REG_DATA_OFS   = 8'h08;

    // Default busy flag position inside the status register
    localparam int DEFAULT_BUSY_BIT = 0;

    // Converts a 3-bit requester index into an 8-bit one-hot vector
    function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req_valid upward starting at rr+1 and wrapping at NUM_REQ; the
// first set bit wins.
// Ports:
//   req_valid  in  NUM_REQ  pending requests
//   rr         in  3        index of the last granted requester
//   grant      out 3        index of the winning requester (0 when none)
//   any_valid  out 1        at least one request is pending
module spi_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [2:0]         rr,
    output logic [2:0]         grant,
    output logic               any_valid
);

    int                 idx_s;
    logic [NUM_REQ-1:0] shifted_s;

    // First-set search from rr+1 with wrap. The loop walks from the farthest
    // candidate to the nearest so the nearest valid one overwrites the rest.
    always_comb begin
        grant     = 3'd0;
        any_valid = 1'b0;
        idx_s     = 0;
        shifted_s = {NUM_REQ{1'b0}};
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx_s     = (int'(rr) + i) % NUM_REQ;
            shifted_s = req_valid >> idx_s;
            grant     = shifted_s[0] ? 3'(idx_s) : grant;
            any_valid = any_valid | shifted_s[0];
        end
    end

endmodule

// File: rtl/spi_req_scheduler.sv
// Round-robin scheduler sharing one spi_controller between NUM_REQ
// requesters. For each granted request it writes the control register, then
// the data register (which launches the transfer), waits for the busy flag
// to rise and fall, and returns the received data word to the owner. A
// transfer whose busy flag does not complete within TIMEOUT_CYCLES returns
// an error response instead.
// Ports:
//   FCLK_CLK0            in   clock, rising edge
//   RST                  in   synchronous active-high reset
//   req_valid/ctrl/data  in   per-requester request, 32-bit words packed by index
//   req_ready            out  one-hot accept pulse (combinational, IDLE only)
//   rsp_valid            out  one-hot one-cycle response pulse
//   rsp_data, rsp_err    out  response payload and timeout flag
//   o_owner              out  index of current/last granted requester
//   o_busy               out  high in every state except IDLE
//   o_data_to_registers  out  write data towards spi_controller
//   o_wr_controll_reg    out  control register write strobe
//   o_wr_data_reg        out  data register write strobe (starts transfer)
//   i_status_reg         in   spi_controller status register
//   i_data_reg           in   spi_controller data register (receive data)
module spi_req_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int BUSY_BIT       = DEFAULT_BUSY_BIT
) (
    input  logic                   FCLK_CLK0,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_ctrl,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   rsp_err,
    output logic [2:0]             o_owner,
    output logic                   o_busy,
    output logic [31:0]            o_data_to_registers,
    output logic                   o_wr_controll_reg,
    output logic                   o_wr_data_reg,
    input  logic [31:0]            i_status_reg,
    input  logic [31:0]            i_data_reg
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Counter value on which the next increment would reach TIMEOUT_CYCLES-1;
    // leaving here makes RESP land TIMEOUT_CYCLES cycles after the data strobe.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [2:0]         state_r;
    logic [2:0]         rr_r;
    logic [2:0]         owner_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        data_lat_r;
    logic [31:0]        wdata_r;
    logic               wr_ctrl_r;
    logic               wr_data_r;
    logic               busy_out_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [31:0]        rsp_data_r;
    logic               rsp_err_r;

    logic [2:0]         grant_s;
    logic               any_valid_s;
    logic               accept_s;
    logic [31:0]        sel_ctrl_s;
    logic [31:0]        sel_data_s;
    logic               status_busy_s;
    logic               timeout_hit_s;
    logic               unused_status_s;

    spi_rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_arbiter (
        .req_valid (req_valid),
        .rr        (rr_r),
        .grant     (grant_s),
        .any_valid (any_valid_s)
    );

    assign status_busy_s   = i_status_reg[BUSY_BIT];
    assign unused_status_s = ^i_status_reg;
    assign timeout_hit_s   = (cnt_r == CNT_LAST);

    // Accept only in IDLE and never while reset is asserted, so a handshake
    // cannot be seen by a requester and then discarded by the reset.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && any_valid_s && !RST;
        if (accept_s) begin
            req_ready = NUM_REQ'(idx_to_onehot(grant_s));
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Select the granted requester's control and data words (AND-OR mux)
    always_comb begin
        sel_ctrl_s = 32'h0000_0000;
        sel_data_s = 32'h0000_0000;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_ctrl_s = sel_ctrl_s | (req_ctrl[32*k +: 32] & {32{grant_s == 3'(k)}});
            sel_data_s = sel_data_s | (req_data[32*k +: 32] & {32{grant_s == 3'(k)}});
        end
    end

    // Scheduler FSM; every output is registered here, one cycle ahead of the
    // state in which it must be visible.
    always_ff @(posedge FCLK_CLK0) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            rr_r        <= 3'(NUM_REQ - 1);
            owner_r     <= 3'd0;
            cnt_r       <= {CNT_W{1'b0}};
            data_lat_r  <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            wr_ctrl_r   <= 1'b0;
            wr_data_r   <= 1'b0;
            busy_out_r  <= 1'b0;
            rsp_valid_r <= {NUM_REQ{1'b0}};
            rsp_data_r  <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            wr_ctrl_r   <= 1'b0;
            wr_data_r   <= 1'b0;
            rsp_valid_r <= {NUM_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r    <= ST_WR_CTRL;
                        rr_r       <= grant_s;
                        owner_r    <= grant_s;
                        data_lat_r <= sel_data_s;
                        wdata_r    <= sel_ctrl_s;
                        wr_ctrl_r  <= 1'b1;
                        busy_out_r <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        busy_out_r <= 1'b0;
                    end
                end
                ST_WR_CTRL: begin
                    state_r   <= ST_WR_DATA;
                    wdata_r   <= data_lat_r;
                    wr_data_r <= 1'b1;
                end
                ST_WR_DATA: begin
                    state_r <= ST_WAIT_START;
                    cnt_r   <= {CNT_W{1'b0}};
                end
                ST_WAIT_START: begin
                    cnt_r <= cnt_r + 1'b1;
                    if (status_busy_s) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (timeout_hit_s) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= NUM_REQ'(idx_to_onehot(owner_r));
                        rsp_data_r  <= 32'h0000_0000;
                        rsp_err_r   <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT_START;
                    end
                end
                ST_WAIT_DONE: begin
                    cnt_r <= cnt_r + 1'b1;
                    if (!status_busy_s) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= NUM_REQ'(idx_to_onehot(owner_r));
                        rsp_data_r  <= i_data_reg;
                        rsp_err_r   <= 1'b0;
                    end else if (timeout_hit_s) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= NUM_REQ'(idx_to_onehot(owner_r));
                        rsp_data_r  <= 32'h0000_0000;
                        rsp_err_r   <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_RESP: begin
                    state_r    <= ST_IDLE;
                    busy_out_r <= 1'b0;
                    rsp_data_r <= 32'h0000_0000;
                    rsp_err_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_out_r <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid           = rsp_valid_r;
    assign rsp_data            = rsp_data_r;
    assign rsp_err             = rsp_err_r;
    assign o_owner             = owner_r;
    assign o_busy              = busy_out_r;
    assign o_data_to_registers = wdata_r;
    assign o_wr_controll_reg   = wr_ctrl_r;
    assign o_wr_data_reg       = wr_data_r;

endmodule

// File: tb/tb_spi_req_scheduler.sv
// Scoreboard bench for spi_req_scheduler: a two-requester instance with a
// configurable spi_controller model, plus a one-requester instance.
module tb_spi_req_scheduler;

    localparam int NR = 2;
    localparam int TO = 16;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [31:0]      tb_ctrl [NR];
    logic [31:0]      tb_data [NR];
    logic [32*NR-1:0] req_ctrl;
    logic [32*NR-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic [2:0]       o_owner;
    logic             o_busy;
    logic [31:0]      o_data_to_registers;
    logic             o_wr_controll_reg;
    logic             o_wr_data_reg;
    logic [31:0]      i_status_reg;
    logic [31:0]      i_data_reg;

    logic [0:0]  req_valid1;
    logic [31:0] req_ctrl1;
    logic [31:0] req_data1;
    logic [0:0]  req_ready1;
    logic [0:0]  rsp_valid1;
    logic [31:0] rsp_data1;
    logic        rsp_err1;
    logic [2:0]  o_owner1;
    logic        o_busy1;
    logic [31:0] o_data1;
    logic        o_wr_ctrl1;
    logic        o_wr_data1;
    logic [31:0] i_status_reg1;
    logic [31:0] i_data_reg1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_grants = 0;
    int last_grant_cyc = 0;
    int n_grants1 = 0;
    int n_rsp1    = 0;
    int last_grant1 = 0;

    // controller model configuration (applies to the next data strobe)
    int          cfg_rise;
    int          cfg_fall;
    bit          cfg_never;
    logic [31:0] cfg_rx;
    // latched model state
    int          m_strobe;
    int          m_rise;
    int          m_fall;
    bit          m_never;
    bit          m_active;
    logic [31:0] m_rx;
    int          m_d;
    logic        busy_m;
    logic        busy1;

    typedef struct { int idx; int cyc; } grant_t;
    typedef struct { bit is_data; logic [31:0] val; int cyc; } strobe_t;
    typedef struct { int idx; logic [31:0] data; bit err; int cyc; } rsp_t;
    grant_t  gq[$];
    strobe_t sq[$];
    rsp_t    rq[$];

    assign req_ctrl = {tb_ctrl[1], tb_ctrl[0]};
    assign req_data = {tb_data[1], tb_data[0]};
    assign i_status_reg = {26'd0, 1'b1, 4'd0, busy_m};
    assign m_d = cyc + 1 - m_strobe;
    assign req_ctrl1 = 32'h0000_0011;
    assign req_data1 = 32'h0000_0022;
    assign i_status_reg1 = {31'd0, busy1};
    assign i_data_reg1 = 32'hC0DE_0001;

    spi_req_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .BUSY_BIT(0)) dut (
        .FCLK_CLK0(clk), .RST(rst), .req_valid(req_valid), .req_ctrl(req_ctrl),
        .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .o_owner(o_owner), .o_busy(o_busy),
        .o_data_to_registers(o_data_to_registers), .o_wr_controll_reg(o_wr_controll_reg),
        .o_wr_data_reg(o_wr_data_reg), .i_status_reg(i_status_reg), .i_data_reg(i_data_reg)
    );

    spi_req_scheduler #(.NUM_REQ(1), .TIMEOUT_CYCLES(TO), .BUSY_BIT(0)) dut1 (
        .FCLK_CLK0(clk), .RST(rst), .req_valid(req_valid1), .req_ctrl(req_ctrl1),
        .req_data(req_data1), .req_ready(req_ready1), .rsp_valid(rsp_valid1),
        .rsp_data(rsp_data1), .rsp_err(rsp_err1), .o_owner(o_owner1), .o_busy(o_busy1),
        .o_data_to_registers(o_data1), .o_wr_controll_reg(o_wr_ctrl1),
        .o_wr_data_reg(o_wr_data1), .i_status_reg(i_status_reg1), .i_data_reg(i_data_reg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // controller model: latch the configuration when the data strobe is seen
    always @(negedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
        end else if (o_wr_data_reg) begin
            m_strobe <= cyc;
            m_rise   <= cfg_rise;
            m_fall   <= cfg_fall;
            m_never  <= cfg_never;
            m_rx     <= cfg_rx;
            m_active <= 1'b1;
        end
    end

    // controller model: busy high for strobe+rise .. strobe+fall-1; receive
    // data valid from the fall cycle on, garbage before it
    always @(posedge clk) begin
        busy_m     <= m_active && !m_never && (m_d >= m_rise) && (m_d < m_fall);
        i_data_reg <= (m_active && (m_d >= m_fall)) ? m_rx : 32'hDEAD_BEEF;
        busy1      <= o_wr_data1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_expired(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : monitor
        grant_t  g;
        strobe_t s;
        rsp_t    r;
        if (req_ready != '0) begin
            n_grants++;
            last_grant_cyc = cyc;
            check("busy_in_idle", 32'(o_busy), 32'd0);
            if (gq.size() == 0) begin
                check("unexpected_grant", 32'(req_ready), 32'd0);
            end else begin
                g = gq.pop_front();
                check("grant_onehot", 32'(req_ready), 32'd1 << g.idx);
                if (g.cyc >= 0) check("grant_cycle", 32'(cyc), 32'(g.cyc));
                sq.push_back('{is_data: 1'b0, val: tb_ctrl[g.idx], cyc: cyc + 1});
                sq.push_back('{is_data: 1'b1, val: tb_data[g.idx], cyc: cyc + 2});
                if (cfg_never)
                    rq.push_back('{idx: g.idx, data: 32'h0, err: 1'b1, cyc: cyc + 2 + TO});
                else
                    rq.push_back('{idx: g.idx, data: cfg_rx, err: 1'b0, cyc: cyc + 3 + cfg_fall});
            end
        end
        if (o_wr_controll_reg || o_wr_data_reg) begin
            check("strobe_overlap", 32'(o_wr_controll_reg & o_wr_data_reg), 32'd0);
            if (sq.size() == 0) begin
                check("unexpected_strobe", 32'({o_wr_controll_reg, o_wr_data_reg}), 32'd0);
            end else begin
                s = sq.pop_front();
                check("strobe_kind", 32'(o_wr_data_reg), 32'(s.is_data));
                check("strobe_value", o_data_to_registers, s.val);
                check("strobe_cycle", 32'(cyc), 32'(s.cyc));
            end
        end
        if (rsp_valid != '0) begin
            if (rq.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                r = rq.pop_front();
                check("rsp_onehot", 32'(rsp_valid), 32'd1 << r.idx);
                check("rsp_data", rsp_data, r.data);
                check("rsp_err", 32'(rsp_err), 32'(r.err));
                check("rsp_cycle", 32'(cyc), 32'(r.cyc));
                check("rsp_owner", 32'(o_owner), 32'(r.idx));
                check("rsp_busy", 32'(o_busy), 32'd1);
            end
        end
        if (req_ready1 != '0) begin
            n_grants1++;
            if (n_grants1 > 1) check("n1_grant_interval", 32'(cyc - last_grant1), 32'd6);
            last_grant1 = cyc;
        end
        if (rsp_valid1 != '0) begin
            n_rsp1++;
            check("n1_rsp_valid", 32'(rsp_valid1), 32'd1);
            check("n1_rsp_data", rsp_data1, 32'hC0DE_0001);
            check("n1_rsp_err", 32'(rsp_err1), 32'd0);
            check("n1_owner", 32'(o_owner1), 32'd0);
            check("n1_rsp_cycle", 32'(cyc), 32'(last_grant1 + 5));
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_owner"}, 32'(o_owner), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_wdata"}, o_data_to_registers, 32'd0);
        check({tag, "_wr_ctrl"}, 32'(o_wr_controll_reg), 32'd0);
        check({tag, "_wr_data"}, 32'(o_wr_data_reg), 32'd0);
        check({tag, "_busy1"}, 32'(o_busy1), 32'd0);
    endtask

    // waits until n_grants reaches target, then returns just after the next edge
    task automatic wait_grants(input int target, input int budget);
        int left;
        left = budget;
        while (n_grants < target && left > 0) begin
            @(negedge clk); #1;
            left--;
        end
        if (n_grants < target) bound_expired("wait_grant");
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int budget);
        int left;
        left = budget;
        while ((gq.size() != 0 || sq.size() != 0 || rq.size() != 0) && left > 0) begin
            @(negedge clk); #1;
            left--;
        end
        if (gq.size() != 0 || sq.size() != 0 || rq.size() != 0) bound_expired("wait_idle");
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int tg;
        int left;
        rst = 1'b1;
        req_valid = '0;
        req_valid1 = '0;
        tb_ctrl[0] = 32'h0; tb_ctrl[1] = 32'h0;
        tb_data[0] = 32'h0; tb_data[1] = 32'h0;
        cfg_rise = 1; cfg_fall = 8; cfg_never = 1'b0; cfg_rx = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // single request from requester 0
        tb_ctrl[0] = 32'h0000_0081; tb_data[0] = 32'h0000_00A5;
        cfg_rise = 1; cfg_fall = 8; cfg_never = 1'b0; cfg_rx = 32'h0000_005A;
        gq.push_back('{idx: 0, cyc: -1});
        req_valid[0] = 1'b1;
        wait_grants(n_grants + 1, 50);
        req_valid[0] = 1'b0;
        wait_idle(60);

        // reset restores priority to requester 0; both valid for 4 transfers
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tb_ctrl[0] = 32'h0000_0100; tb_data[0] = 32'h0000_0200;
        tb_ctrl[1] = 32'h0000_0101; tb_data[1] = 32'h0000_0201;
        cfg_rise = 1; cfg_fall = 2; cfg_rx = 32'h0000_003C;
        gq.push_back('{idx: 0, cyc: -1});
        gq.push_back('{idx: 1, cyc: -1});
        gq.push_back('{idx: 0, cyc: -1});
        gq.push_back('{idx: 1, cyc: -1});
        req_valid = 2'b11;
        wait_grants(n_grants + 4, 100);
        req_valid = 2'b00;
        wait_idle(60);

        // timeout on requester 1; requester 0 waiting is accepted right after RESP
        tb_ctrl[1] = 32'h0000_0033; tb_data[1] = 32'h0000_0044;
        cfg_never = 1'b1;
        gq.push_back('{idx: 1, cyc: -1});
        req_valid[1] = 1'b1;
        wait_grants(n_grants + 1, 50);
        req_valid[1] = 1'b0;
        tg = last_grant_cyc;
        repeat (3) @(posedge clk);
        #1;
        cfg_never = 1'b0; cfg_rise = 1; cfg_fall = 8; cfg_rx = 32'h0000_0077;
        tb_ctrl[0] = 32'h0000_0055; tb_data[0] = 32'h0000_0066;
        gq.push_back('{idx: 0, cyc: tg + 2 + TO + 1});
        req_valid[0] = 1'b1;
        wait_grants(n_grants + 1, 60);
        req_valid[0] = 1'b0;

        // requester 1 raises during requester 0's WAIT_DONE
        tg = last_grant_cyc;
        repeat (5) @(posedge clk);
        #1;
        tb_ctrl[1] = 32'h0000_0099; tb_data[1] = 32'h0000_00AA;
        gq.push_back('{idx: 1, cyc: tg + 12});
        req_valid[1] = 1'b1;
        wait_grants(n_grants + 1, 60);
        req_valid[1] = 1'b0;
        wait_idle(60);

        // requester 0 transfer aborted by reset in WAIT_DONE
        tb_ctrl[0] = 32'h0000_0E01; tb_data[0] = 32'h0000_0E02;
        cfg_rx = 32'h0000_0E03;
        gq.push_back('{idx: 0, cyc: -1});
        req_valid[0] = 1'b1;
        wait_grants(n_grants + 1, 50);
        req_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rq.delete();
        @(negedge clk);
        check_zero("abort");
        @(posedge clk); #1;
        tb_ctrl[1] = 32'h0000_0F01; tb_data[1] = 32'h0000_0F02;
        gq.push_back('{idx: 0, cyc: -1});
        gq.push_back('{idx: 1, cyc: -1});
        req_valid = 2'b11;
        wait_grants(n_grants + 2, 60);
        req_valid = 2'b00;
        wait_idle(60);

        // single-requester build, back-to-back
        req_valid1 = 1'b1;
        left = 100;
        while (n_grants1 < 3 && left > 0) begin
            @(negedge clk); #1;
            left--;
        end
        if (n_grants1 < 3) bound_expired("n1_grants");
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        left = 40;
        while (n_rsp1 < 3 && left > 0) begin
            @(negedge clk); #1;
            left--;
        end
        if (n_rsp1 < 3) bound_expired("n1_rsps");
        repeat (10) @(posedge clk);
        #1;
        check("n1_grant_count", 32'(n_grants1), 32'd3);
        check("n1_rsp_count", 32'(n_rsp1), 32'd3);
        check("grant_queue_empty", 32'(gq.size()), 32'd0);
        check("rsp_queue_empty", 32'(rq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
